// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared constants for the parking occupancy controller: gate state encodings and
// default sizing for the car park and barrier hold time.
package parking_occupancy_ctrl_pkg;

  localparam logic [0:0] GATE_CLOSED = 1'b0;
  localparam logic [0:0] GATE_OPEN   = 1'b1;

  localparam int unsigned DEF_CAPACITY  = 8;
  localparam int unsigned DEF_GATE_HOLD = 50000000;

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Bundle of sensor pulses in and occupancy/gate status out. The master side is the
// edge-detection stage plus display logic; the slave side is the controller.
interface parking_occupancy_ctrl_if #(
  parameter int unsigned CNT_W = 4
);

  logic             entry_pulse;
  logic             exit_pulse;
  logic [CNT_W-1:0] occupied;
  logic [CNT_W-1:0] free_spaces;
  logic             full;
  logic             empty;
  logic             entry_gate_open;
  logic             exit_gate_open;
  logic             entry_denied;
  logic             exit_error;

  modport master (
    output entry_pulse,
    output exit_pulse,
    input  occupied,
    input  free_spaces,
    input  full,
    input  empty,
    input  entry_gate_open,
    input  exit_gate_open,
    input  entry_denied,
    input  exit_error
  );

  modport slave (
    input  entry_pulse,
    input  exit_pulse,
    output occupied,
    output free_spaces,
    output full,
    output empty,
    output entry_gate_open,
    output exit_gate_open,
    output entry_denied,
    output exit_error
  );

endinterface

// File: rtl/parking_gate_timer.sv
// One barrier gate: opens on an accepted pulse and stays open for GATE_HOLD cycles
// after the most recent accepted pulse.
module parking_gate_timer
  import parking_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned GATE_HOLD = DEF_GATE_HOLD,
  parameter int unsigned HOLD_W    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic gate_open
);

  localparam logic [HOLD_W-1:0] HoldReload = HOLD_W'(GATE_HOLD - 1);

  logic [0:0]        r_state;
  logic [HOLD_W-1:0] r_timer;

  // A trigger always wins, so a pulse landing on the final open cycle extends the hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= GATE_CLOSED;
      r_timer <= '0;
    end else if (trigger) begin
      r_state <= GATE_OPEN;
      r_timer <= HoldReload;
    end else if (r_state == GATE_OPEN) begin
      if (r_timer == '0) begin
        r_state <= GATE_CLOSED;
      end else begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign gate_open = (r_state == GATE_OPEN);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy counter, entry/exit acceptance, full/empty decode and reject pulses,
// driving one hold timer per barrier gate.
module parking_occupancy_ctrl
  import parking_occupancy_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY  = DEF_CAPACITY,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GATE_HOLD = DEF_GATE_HOLD,
  parameter int unsigned HOLD_W    = 26
) (
  input  logic                     clk,
  input  logic                     reset,
  parking_occupancy_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] Cap = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] r_occ;
  logic             r_entry_denied;
  logic             r_exit_error;

  logic             w_full;
  logic             w_empty;
  logic             w_acc_in;
  logic             w_acc_out;
  logic [CNT_W-1:0] w_occ_d;

  assign w_full    = (r_occ == Cap);
  assign w_empty   = (r_occ == '0);
  assign w_acc_out = bus.exit_pulse & ~w_empty;
  // When full, a simultaneous accepted exit frees the space the entering car takes.
  assign w_acc_in  = bus.entry_pulse & (~w_full | w_acc_out);

  always_comb begin
    w_occ_d = r_occ;
    if (w_acc_in && !w_acc_out) begin
      w_occ_d = r_occ + 1'b1;
    end else if (w_acc_out && !w_acc_in) begin
      w_occ_d = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ          <= '0;
      r_entry_denied <= 1'b0;
      r_exit_error   <= 1'b0;
    end else begin
      r_occ          <= w_occ_d;
      r_entry_denied <= bus.entry_pulse & ~w_acc_in;
      r_exit_error   <= bus.exit_pulse & ~w_acc_out;
    end
  end

  assign bus.occupied     = r_occ;
  assign bus.free_spaces  = Cap - r_occ;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.entry_denied = r_entry_denied;
  assign bus.exit_error   = r_exit_error;

  parking_gate_timer #(
    .GATE_HOLD (GATE_HOLD),
    .HOLD_W    (HOLD_W)
  ) u_entry_gate (
    .clk       (clk),
    .reset     (reset),
    .trigger   (w_acc_in),
    .gate_open (bus.entry_gate_open)
  );

  parking_gate_timer #(
    .GATE_HOLD (GATE_HOLD),
    .HOLD_W    (HOLD_W)
  ) u_exit_gate (
    .clk       (clk),
    .reset     (reset),
    .trigger   (w_acc_out),
    .gate_open (bus.exit_gate_open)
  );

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl (CAPACITY=3, GATE_HOLD=4) with a
// behavioural model feeding an expectation queue.
module tb_parking_occupancy_ctrl;

  localparam int Cap  = 3;
  localparam int Hold = 4;
  localparam int Far  = 1000;

  typedef struct packed {
    logic [3:0] occ;
    logic [3:0] free;
    logic       full;
    logic       empty;
    logic       eg;
    logic       xg;
    logic       den;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  parking_occupancy_ctrl_if #(.CNT_W(4)) bus ();

  parking_occupancy_ctrl #(
    .CAPACITY  (Cap),
    .CNT_W     (4),
    .GATE_HOLD (Hold),
    .HOLD_W    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  int   m_occ   = 0;
  int   m_eage  = Far;
  int   m_xage  = Far;
  exp_t q[$];

  // Model: ages count cycles since the last accepted pulse; a gate is open while age < Hold.
  task automatic predict(input logic e, input logic x);
    exp_t ex;
    bit   ai;
    bit   ao;
    ao = x && (m_occ > 0);
    ai = e && ((m_occ < Cap) || ao);
    ex.den = e && !ai;
    ex.err = x && !ao;
    m_occ  = m_occ + (ai ? 1 : 0) - (ao ? 1 : 0);
    m_eage = ai ? 0 : ((m_eage < Far) ? m_eage + 1 : m_eage);
    m_xage = ao ? 0 : ((m_xage < Far) ? m_xage + 1 : m_xage);
    ex.occ   = 4'(m_occ);
    ex.free  = 4'(Cap - m_occ);
    ex.full  = (m_occ == Cap);
    ex.empty = (m_occ == 0);
    ex.eg    = (m_eage < Hold);
    ex.xg    = (m_xage < Hold);
    q.push_back(ex);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag);
    exp_t ex;
    if (q.size() == 0) begin
      n_total++;
      $error("FAIL %s: no expectation queued", tag);
    end else begin
      ex = q.pop_front();
      chk({tag, " occupied"},     bus.occupied,               ex.occ);
      chk({tag, " free_spaces"},  bus.free_spaces,            ex.free);
      chk({tag, " full"},         {3'b0, bus.full},           {3'b0, ex.full});
      chk({tag, " empty"},        {3'b0, bus.empty},          {3'b0, ex.empty});
      chk({tag, " entry_gate"},   {3'b0, bus.entry_gate_open}, {3'b0, ex.eg});
      chk({tag, " exit_gate"},    {3'b0, bus.exit_gate_open}, {3'b0, ex.xg});
      chk({tag, " entry_denied"}, {3'b0, bus.entry_denied},   {3'b0, ex.den});
      chk({tag, " exit_error"},   {3'b0, bus.exit_error},     {3'b0, ex.err});
    end
  endtask

  task automatic cycle(input logic e, input logic x, input string tag);
    @(negedge clk);
    bus.entry_pulse = e;
    bus.exit_pulse  = x;
    predict(e, x);
    @(posedge clk);
    #1;
    bus.entry_pulse = 1'b0;
    bus.exit_pulse  = 1'b0;
    check_out(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
  endtask

  // Reset raised between edges with pulses present: outputs must clear before any edge.
  task automatic do_reset(input logic e, input logic x, input string tag);
    @(negedge clk);
    bus.entry_pulse = e;
    bus.exit_pulse  = x;
    reset  = 1'b1;
    m_occ  = 0;
    m_eage = Far;
    m_xage = Far;
    predict(1'b0, 1'b0);
    #1;
    check_out({tag, " async"});
    @(posedge clk);
    #1;
    predict(1'b0, 1'b0);
    check_out({tag, " held"});
    @(negedge clk);
    reset           = 1'b0;
    bus.entry_pulse = 1'b0;
    bus.exit_pulse  = 1'b0;
  endtask

  initial begin
    bus.entry_pulse = 1'b0;
    bus.exit_pulse  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    predict(1'b0, 1'b0);
    check_out("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fill up with spaced entries
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, "fill");
      idle(4, "fill_idle");
    end

    // Entry refused when full
    cycle(1'b1, 1'b0, "deny");
    idle(1, "deny_after");

    // Drain, exit on empty, then simultaneous entry+exit on empty
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, "drain");
      idle(4, "drain_idle");
    end
    cycle(1'b0, 1'b1, "exit_empty");
    idle(1, "exit_empty_after");
    cycle(1'b1, 1'b1, "both_empty");
    idle(4, "both_empty_idle");

    // Simultaneous entry+exit while full
    cycle(1'b1, 1'b0, "refill");
    cycle(1'b1, 1'b0, "refill");
    idle(4, "refill_idle");
    cycle(1'b1, 1'b1, "both_full");
    idle(5, "both_full_hold");

    // Retriggered entry gate
    cycle(1'b0, 1'b1, "make_room");
    cycle(1'b0, 1'b1, "make_room");
    idle(4, "make_room_idle");
    cycle(1'b1, 1'b0, "retrig_t0");
    idle(2, "retrig_mid");
    cycle(1'b1, 1'b0, "retrig_t3");
    idle(6, "retrig_hold");

    // Reset while the exit gate is open and occupied=2
    cycle(1'b0, 1'b1, "pre_reset");
    do_reset(1'b1, 1'b1, "mid_reset");
    cycle(1'b1, 1'b0, "post_reset");
    idle(5, "post_reset_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
